// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers host bytes in a small FIFO and streams one message
// at a time into a hash core, then waits for the core's completion level and
// captures its digest.
// Optional feature macro: HASH_FEEDER_DIGEST_CHECK_EN adds exp_digest / match,
// a registered comparison of the captured digest against an expected value.
module hash_msg_feeder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] msg_len,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        busy,
  output logic        M_valid,
  output logic [63:0] C_in,
  output logic [7:0]  M,
  input  logic        hash_ready,
  input  logic [31:0] digest_in,
  output logic        done,
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
  input  logic [31:0] exp_digest,
  output logic [0:0]  match,
`endif
  output logic [31:0] digest
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Byte buffer storage and bookkeeping
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  // Message and output registers
  logic [63:0]   remaining_r;
  logic [63:0]   c_in_r;
  logic          m_valid_r;
  logic [7:0]    m_r;
  logic          done_r;
  logic [31:0]   digest_r;
  logic          armed_r;

  // Per-cycle control decoded from the FSM
  logic          load_s;
  logic          emit_zero_s;
  logic          capture_s;

  assign full_s  = (count_r == (AW+1)'(FIFO_DEPTH));
  assign empty_s = (count_r == {(AW+1){1'b0}});
  assign push_s  = s_valid & ~full_s;

  assign s_ready = ~full_s;
  assign busy    = (state_r != IDLE);
  assign M_valid = m_valid_r;
  assign M       = m_r;
  assign C_in    = c_in_r;
  assign done    = done_r;
  assign digest  = digest_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    pop_s       = 1'b0;
    emit_zero_s = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        // remaining is only zero here on entry with a zero-length message:
        // the last real byte always moves the FSM straight to WAIT.
        if (remaining_r == 64'd0) begin
          emit_zero_s = 1'b1;
          state_nxt_s = WAIT;
        end else if (!empty_s) begin
          pop_s = 1'b1;
          if (remaining_r == 64'd1) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = SEND;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      WAIT: begin
        if (armed_r && hash_ready) begin
          capture_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FIFO storage write port (contents need no reset; occupancy is reset)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Message length, byte stream to the core, and digest capture
  always_ff @(posedge clk) begin
    if (rst) begin
      c_in_r      <= 64'd0;
      remaining_r <= 64'd0;
      m_valid_r   <= 1'b0;
      m_r         <= 8'h00;
      done_r      <= 1'b0;
      digest_r    <= 32'h0000_0000;
    end else begin
      if (load_s) begin
        c_in_r      <= msg_len;
        remaining_r <= msg_len;
      end else if (pop_s) begin
        remaining_r <= remaining_r - 64'd1;
      end
      m_valid_r <= pop_s | emit_zero_s;
      if (pop_s) begin
        m_r <= mem_r[rd_ptr_r];
      end else if (emit_zero_s) begin
        m_r <= 8'h00;
      end
      done_r <= capture_s;
      if (capture_s) begin
        digest_r <= digest_in;
      end
    end
  end

  // Completion arming: a level already high when WAIT is entered is stale,
  // so the core must be seen low at least once in WAIT before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r <= 1'b0;
    end else if (state_r != WAIT) begin
      armed_r <= 1'b0;
    end else if (!hash_ready) begin
      armed_r <= 1'b1;
    end
  end

`ifdef HASH_FEEDER_DIGEST_CHECK_EN
  logic match_r;
  assign match = match_r;

  // Digest comparison, updated together with the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      match_r <= 1'b0;
    end else if (capture_s) begin
      match_r <= (digest_in == exp_digest);
    end
  end
`endif

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed + randomized bench for hash_msg_feeder. The model is a byte queue
// holding what the FIFO should contain; each message must emit its bytes in
// queue order (or a single 0x00 for a zero-length message).
module tb_hash_msg_feeder;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] msg_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        busy;
  logic        M_valid;
  logic [63:0] C_in;
  logic [7:0]  M;
  logic        hash_ready;
  logic [31:0] digest_in;
  logic        done;
  logic [31:0] digest;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
  logic [31:0] exp_digest;
  logic [0:0]  match;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] mq[$];
  int first_c;
  int last_c;

  hash_msg_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msg_len    (msg_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .busy       (busy),
    .M_valid    (M_valid),
    .C_in       (C_in),
    .M          (M),
    .hash_ready (hash_ready),
    .digest_in  (digest_in),
    .done       (done),
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
    .exp_digest (exp_digest),
    .match      (match),
`endif
    .digest     (digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic push(input logic [7:0] b);
    chk("s_ready_before_push", s_ready, (mq.size() < DEPTH));
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(b);
  endtask

  // Run one message: start, optional pushes every 'period' cycles, a model
  // hash core (stale = completion level already high before WAIT), and an
  // optional start pulse while busy that must be ignored.
  task automatic run_msg(input logic [63:0] len, input int period, input int npush,
                         input bit stale, input bit glitch, input logic [31:0] dg);
    int got, pushed, after, hs, expn;
    bit fin;
    bit want_match;
    logic [7:0] eb;
    got = 0; pushed = 0; after = -1; fin = 1'b0;
    first_c = -1; last_c = -1;
    hs = stale ? 4 : 1;
    expn = (len == 64'd0) ? 1 : int'(len);
    digest_in = dg;
    want_match = ($urandom_range(0, 1) == 1);
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
    exp_digest = want_match ? dg : (dg ^ 32'h0000_0100);
`endif
    msg_len    = len;
    start      = 1'b1;
    hash_ready = stale;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (pushed < npush && (cyc % period) == 0) begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        chk("s_ready_in_msg", s_ready, 1'b1);
        mq.push_back(s_data);
        pushed++;
      end else begin
        s_valid = 1'b0;
      end
      start = (glitch && cyc == 2);
      if (glitch && cyc == 2) msg_len = len + 64'd7;
      if (after >= 0) hash_ready = stale ? (after != hs - 1) : (after >= hs);
      tick();
      s_valid = 1'b0;
      start   = 1'b0;
      chk("c_in_hold", C_in, len);
      if (after >= 0) begin
        chk("done_timing", done, (after == hs));
        if (after == hs) begin
          chk("digest_capture", digest, dg);
          chk("busy_after_done", busy, 1'b0);
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
          chk("match_value", match, want_match);
`endif
          fin = 1'b1;
        end
        after++;
      end else begin
        chk("no_early_done", done, 1'b0);
      end
      if (M_valid) begin
        chk("m_valid_not_extra", (got < expn), 1'b1);
        if (len == 64'd0) eb = 8'h00;
        else if (mq.size() > 0) eb = mq.pop_front();
        else eb = 8'hxx;
        chk("m_byte", M, eb);
        got++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (got == expn) after = 0;
      end
    end
    if (!fin) chk("timeout_waiting_done", 1'b0, 1'b1);
    chk("pulse_count", got, expn);
    hash_ready = 1'b0;
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("m_valid_idle", M_valid, 1'b0);
    chk("digest_hold", digest, dg);
  endtask

  initial begin
    int pre, np, room, per;
    logic [63:0] ln;
    rst = 1'b1; start = 1'b0; msg_len = 64'd0; s_valid = 1'b0; s_data = 8'h00;
    hash_ready = 1'b0; digest_in = 32'h0;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
    exp_digest = 32'h0;
`endif

    // Reset values
    do_reset(2);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_valid", M_valid, 1'b0);
    chk("rst_m", M, 8'h00);
    chk("rst_c_in", C_in, 64'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_digest", digest, 32'h0);
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
    chk("rst_match", match, 1'b0);
`endif

    // Three prefilled bytes stream back-to-back
    push(8'h61); push(8'h62); push(8'h63);
    run_msg(64'd3, 1, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("abc_consecutive", last_c - first_c, 2);

    // Zero-length message with empty FIFO
    run_msg(64'd0, 1, 0, 1'b0, 1'b0, 32'h1234_5678);
    chk("zero_len_fifo_empty", s_ready, 1'b1);

    // Slow producer: gaps between bytes, fifth byte left behind
    run_msg(64'd4, 3, 5, 1'b0, 1'b0, 32'hCAFE_F00D);
    chk("slow_has_gaps", (last_c - first_c > 3), 1'b1);
    chk("leftover_count", mq.size(), 1);
    run_msg(64'd1, 1, 0, 1'b0, 1'b0, 32'h0BAD_CAFE);

    // Fill to depth; 17th byte dropped
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    chk("s_ready_full", s_ready, 1'b0);
    push(8'hEE);
    chk("model_full", mq.size(), DEPTH);
    // Full message with stale completion level and a start pulse while busy
    run_msg(64'(DEPTH), 1, 0, 1'b1, 1'b1, 32'hA5A5_5A5A);
    chk("drained_ready", s_ready, 1'b1);

    // Randomized messages
    for (int k = 0; k < 8; k++) begin
      room = 12 - mq.size();
      pre  = $urandom_range(0, room / 2);
      np   = $urandom_range(0, room / 2);
      per  = $urandom_range(1, 4);
      for (int i = 0; i < pre; i++) push(8'($urandom));
      ln = 64'($urandom_range(0, mq.size() + np));
      run_msg(ln, per, np, ($urandom_range(0, 1) == 1), 1'b0, $urandom);
    end

    // Reset in the middle of SEND
    do_reset(1);
    for (int i = 0; i < 6; i++) push(8'($urandom));
    msg_len = 64'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_send_active", M_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    chk("mid_rst_m_valid", M_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_c_in", C_in, 64'd0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_digest", digest, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_done_after_abort", done, 1'b0);
    end
    push(8'hA5);
    run_msg(64'd1, 1, 0, 1'b0, 1'b0, 32'h5555_AAAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
